// File: rtl/fetch_pkg.sv
// Shared defaults and next-pc select encoding for the fetch PC unit and its
// return-address stack.
package fetch_pkg;

  localparam int          XLEN_DEFAULT         = 64;
  localparam logic [63:0] RESET_VECTOR_DEFAULT = 64'h0;
  localparam int          INST_BYTES_DEFAULT   = 4;
  localparam int          RAS_DEPTH_DEFAULT    = 4;

  typedef enum logic [2:0] {
    REDIRECT,
    HOLD,
    RAS,
    BRANCH,
    SEQ
  } next_pc_sel_e;

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack. When full, a push overwrites the oldest entry
// and the count saturates at RAS_DEPTH.
module return_stack
  import fetch_pkg::*;
#(
  parameter int XLEN      = XLEN_DEFAULT,
  parameter int RAS_DEPTH = RAS_DEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_value,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  entries_q [RAS_DEPTH];
  logic [XLEN-1:0]  entries_d [RAS_DEPTH];
  logic [PTR_W-1:0] top_ptr_q, top_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(RAS_DEPTH));
  assign top   = empty ? '0 : entries_q[top_ptr_q];

  always_comb begin
    entries_d = entries_q;
    top_ptr_d = top_ptr_q;
    count_d   = count_q;
    // A call and return in the same cycle swap the top in place.
    if (push && pop && !empty) begin
      entries_d[top_ptr_q] = push_value;
    end else if (push) begin
      top_ptr_d            = top_ptr_q + 1'b1;
      entries_d[top_ptr_d] = push_value;
      if (!full) count_d = count_q + 1'b1;
    end else if (pop && !empty) begin
      top_ptr_d = top_ptr_q - 1'b1;
      count_d   = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      top_ptr_q <= '0;
      count_q   <= '0;
    end else begin
      top_ptr_q <= top_ptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    entries_q <= entries_d;
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch program counter with redirect/stall/return/branch/sequential priority
// and an attached return-address stack.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
  parameter int              INST_BYTES   = INST_BYTES_DEFAULT,
  parameter int              RAS_DEPTH    = RAS_DEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            stall,
  input  logic            redirectValid,
  input  logic [XLEN-1:0] redirectPc,
  input  logic            branchTaken,
  input  logic [XLEN-1:0] branchTarget,
  input  logic            rasPush,
  input  logic            rasPop,
  output logic [XLEN-1:0] pc,
  output logic            pcValid,
  output logic [XLEN-1:0] rasTop,
  output logic            rasEmpty,
  output logic            rasFull
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INST_BYTES - 1));
  localparam logic [XLEN-1:0] INCR       = XLEN'(INST_BYTES);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            pc_valid_q, pc_valid_d;
  logic            ras_en;
  next_pc_sel_e    sel;

  // The RAS only moves on cycles where the pc actually advances normally.
  assign ras_en = pc_valid_q && !stall && !redirectValid;

  return_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk        (clk),
    .rstN       (rstN),
    .push       (rasPush && ras_en),
    .pop        (rasPop && ras_en),
    .push_value (pc_q + INCR),
    .top        (rasTop),
    .empty      (rasEmpty),
    .full       (rasFull)
  );

  // The first edge out of reset only raises pcValid; the reset vector is fetched first.
  always_comb begin
    sel        = SEQ;
    pc_valid_d = 1'b1;
    if (!pc_valid_q)                  sel = HOLD;
    else if (redirectValid)           sel = REDIRECT;
    else if (stall)                   sel = HOLD;
    else if (rasPop && !rasEmpty)     sel = RAS;
    else if (branchTaken)             sel = BRANCH;

    pc_d = pc_q + INCR;
    case (sel)
      REDIRECT: pc_d = redirectPc & ALIGN_MASK;
      HOLD:     pc_d = pc_q;
      RAS:      pc_d = rasTop & ALIGN_MASK;
      BRANCH:   pc_d = branchTarget & ALIGN_MASK;
      default:  pc_d = pc_q + INCR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      pc_q       <= RESET_VECTOR;
      pc_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
    end
  end

  assign pc      = pc_q;
  assign pcValid = pc_valid_q;

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 64: PC and address width in bits.
REQ-002 The block SHALL have parameter RESET_VECTOR, default 0: PC value loaded on reset.
REQ-003 The block SHALL have parameter INST_BYTES, default 4: sequential increment; power of two, at least 2.
REQ-004 The block SHALL have parameter RAS_DEPTH, default 4: return-address-stack entries; power of two, at least 2.
REQ-005 The block SHALL have ports, one per line (name, direction, width, meaning):
 clk  in  1  single clock; all state updates on posedge.
 rstN  in  1  synchronous, active-low reset.
 stall  in  1  hold PC and RAS.
 redirectValid  in  1  trap/mispredict redirect; highest priority.
 redirectPc  in  XLEN  redirect target.
 branchTaken  in  1  predicted/resolved taken branch.
 branchTarget  in  XLEN  branch target.
 rasPush  in  1  call at current pc; push return address.
 rasPop  in  1  return at current pc; pop RAS for next pc.
 pc  out  XLEN  current fetch address.
 pcValid  out  1  pc is a valid fetch address.
 rasTop  out  XLEN  top-of-stack value, or 0 when empty.
 rasEmpty  out  1  RAS count == 0.
 rasFull  out  1  RAS count == RAS_DEPTH.

Function
REQ-006 Next-pc priority SHALL be, on each posedge with rstN high: redirectValid, then stall (hold), then rasPop with !rasEmpty (pc<=rasTop), then branchTaken (pc<=branchTarget), then pc+INST_BYTES.
REQ-007 redirectValid SHALL override stall; a redirect taken while stall is high SHALL still load redirectPc in that cycle.
REQ-008 The low log2(INST_BYTES) bits of every loaded target SHALL be forced to 0; pc is therefore always aligned.
REQ-009 Increment SHALL wrap modulo 2^XLEN, e.g. all-ones-aligned + INST_BYTES -> 0.
REQ-010 Latency SHALL be one cycle from input sample to new pc; there is no combinational path from any input to pc.
REQ-011 The push value SHALL be pc+INST_BYTES, wrapped per REQ-009.
REQ-012 The RAS SHALL update only when stall is low and redirectValid is low; a redirect leaves RAS contents and count unchanged.
REQ-013 Push while not full SHALL write the top+1 slot and increment count.
REQ-014 Push while full SHALL overwrite the oldest entry (circular); count SHALL stay at RAS_DEPTH.
REQ-015 Pop while not empty SHALL decrement count; pop while empty SHALL be ignored, and the next pc SHALL fall through to branchTaken or the increment.
REQ-016 Simultaneous push and pop while not empty SHALL replace the top entry with the push value; count is unchanged, and pc takes the old top.
REQ-017 Simultaneous push and pop while empty SHALL act as a push only.
REQ-018 rasTop, rasEmpty and rasFull SHALL be registered-state decodes, valid in the same cycle as pc.

Reset
REQ-019 While rstN is low at a posedge: pc<=RESET_VECTOR, pcValid<=0, RAS count<=0; rasEmpty=1, rasFull=0, rasTop=0.
REQ-020 pcValid SHALL rise on the first posedge with rstN high; pc SHALL still equal RESET_VECTOR then, with no increment on that edge.
REQ-021 Reset asserted mid-operation SHALL override every other input in that cycle; RAS entry storage need not be cleared.

Structure
REQ-022 Default parameter values and a next-pc-select enum (REDIRECT, HOLD, RAS, BRANCH, SEQ) SHALL reside in shared package fetch_pkg.
REQ-023 The RAS SHALL be a single sub-module, return_stack, parameterised by XLEN and RAS_DEPTH, with circular top pointer and saturating count.

Verification
REQ-024 Reset: RESET_VECTOR=0x1000; release rstN -> pc=0x1000 and pcValid=1 for one cycle, then 0x1004, 0x1008.
REQ-025 Priority: stall=1, branchTaken=1 (0x2000), redirectValid=1 (0x3003) -> pc=0x3000; next cycle, stall only -> pc holds 0x3000.
REQ-026 Call/return: pc=0x100 with push; jump to 0x800; pop at 0x800 -> pc=0x104, rasEmpty=1.
REQ-027 Overflow: RAS_DEPTH=4, five pushes (returns A..E) -> rasFull=1; four pops -> E, D, C, B; fifth pop ignored, sequential pc.
REQ-028 Simultaneous: stack [X], push+pop at pc=P -> pc=X, top=P+4, count 1; on empty stack -> pc=P+4, top=P+4, count 1.
REQ-029 Wrap: XLEN=32, redirect to 0xFFFFFFFC -> next pc=0x00000000.
